// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin push-side arbiter for a shared FIFO; optional packet lock via ARB_PACKET_LOCK_EN
module fifo_push_arbiter #(
  parameter int  DATA_WIDTH = 32,
  parameter int  N_REQ      = 4,
  localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int PW         = DATA_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ*PW-1:0]   req_data_i,
  output logic [N_REQ-1:0]      req_grant_o,
  output logic [PW-1:0]         push_data_o,
  output logic                  push_valid_o,
  input  logic                  push_grant_i,
  output logic [ID_W-1:0]       owner_o,
  output logic                  busy_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] arb_w;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] nxt;
  logic            sel_hit;
  logic [PW-1:0]   sel_data;
  logic            transfer;
  logic            eop;

  // Round-robin search: first valid requester starting at ptr_q and wrapping
  always_comb begin
    int  idx;
    logic found;
    arb_w = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        arb_w = ID_W'(idx);
      end
    end
  end

`ifdef ARB_PACKET_LOCK_EN
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          state_q;
  logic [ID_W-1:0] owner_q;
  logic            busy_q;

  // While a packet is in flight the selection is pinned to its owner
  assign sel    = (state_q == LOCK) ? owner_q : arb_w;
  assign busy_o = busy_q;
`else
  assign sel    = arb_w;
  assign busy_o = 1'b0;
`endif

  // Data/valid mux for the selected requester
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == sel) begin
        sel_data = req_data_i[i*PW +: PW];
        sel_hit  = req_valid_i[i];
      end
    end
  end

  // With no lock, sel_hit equals |req_valid_i because the winner is always valid
  assign push_valid_o = rst_n && sel_hit;
  assign push_data_o  = push_valid_o ? sel_data : '0;
  assign owner_o      = rst_n ? sel : '0;
  assign transfer     = push_valid_o && push_grant_i;
  assign eop          = sel_data[DATA_WIDTH];
  assign nxt          = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;

  // One-hot grant back to the selected requester on a transfer
  always_comb begin
    req_grant_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_grant_o[i] = transfer && (ID_W'(i) == sel);
    end
  end

`ifdef ARB_PACKET_LOCK_EN
  // Packet lock FSM: enter LOCK on a non-final beat, leave on the EOP beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (transfer) begin
            if (!eop) begin
              state_q <= LOCK;
              owner_q <= sel;
              busy_q  <= 1'b1;
            end else begin
              ptr_q <= nxt;
            end
          end
        end
        LOCK: begin
          if (transfer && eop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= nxt;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
`else
  // Priority pointer rotates past the winner after every accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (transfer) begin
      ptr_q <= nxt;
    end
  end

  logic unused_eop;
  assign unused_eop = eop;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int PW = DW + 1;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_data;
  logic [N-1:0]    req_grant;
  logic [PW-1:0]   push_data;
  logic            push_valid;
  logic            push_grant;
  logic [1:0]      owner;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  int m_ptr  = 0;
  int m_lock = -1;

  fifo_push_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_grant_o  (req_grant),
    .push_data_o  (push_data),
    .push_valid_o (push_valid),
    .push_grant_i (push_grant),
    .owner_o      (owner),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       grant;
    logic [1:0] owner;
    logic [3:0] gnt;
    logic       pvalid;
  } vec_t;

  vec_t tbl [20];

  function automatic logic [N*PW-1:0] pack(input logic [3:0] eop);
    logic [N*PW-1:0] r;
    logic [31:0]     v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      v = 32'hA0 + 32'(i);
      r[i*PW +: PW] = {eop[i], v};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else n_pass++;
  endtask

  // Spec-level model: who is selected now, given ptr and optional lock owner
  task automatic model_eval(input logic [3:0] v, input logic g, input logic [N*PW-1:0] d,
                            output int sel, output logic pv, output logic [3:0] gnt,
                            output logic [PW-1:0] data);
    sel = 0;
    if (m_lock >= 0) begin
      sel = m_lock;
      pv  = v[sel];
    end else begin
      pv = (v != 4'b0);
      for (int k = N - 1; k >= 0; k--)
        if (v[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
    end
    gnt  = (pv && g) ? 4'(1 << sel) : 4'b0;
    data = pv ? d[sel*PW +: PW] : '0;
  endtask

  task automatic model_step(input logic [3:0] v, input logic g, input logic [N*PW-1:0] d);
    int sel; logic pv; logic [3:0] gnt; logic [PW-1:0] data;
    model_eval(v, g, d, sel, pv, gnt, data);
    if (pv && g) begin
`ifdef ARB_PACKET_LOCK_EN
      if (m_lock < 0 && !data[DW]) m_lock = sel;
      else begin m_lock = -1; m_ptr = (sel + 1) % N; end
`else
      m_ptr = (sel + 1) % N;
`endif
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    m_ptr  = 0;
    m_lock = -1;
  endtask

  initial begin
    int sel; logic pv; logic [3:0] gnt; logic [PW-1:0] data;
    logic [PW-1:0] exp_d;
    logic [31:0]   base;

    // Reset with everyone requesting
    rst_n = 1'b0; req_valid = 4'hF; push_grant = 1'b1; req_data = pack(4'hF);
    #3;
    chk("rst_push_valid", 64'(push_valid), 64'd0);
    chk("rst_grant",      64'(req_grant),  64'd0);
    chk("rst_owner",      64'(owner),      64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    next_cycle();
    push_grant = 1'b0;
    rst_n = 1'b1;
    #3;
    chk("release_owner", 64'(owner), 64'd0);
    next_cycle();

    // Directed sequence; every beat carries EOP so both builds behave alike
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 1'b1, 2'(i % 4), 4'(1 << (i % 4)), 1'b1};
    tbl[8]  = '{4'b0100, 1'b0, 2'd2, 4'b0000, 1'b1};
    tbl[9]  = '{4'b0100, 1'b0, 2'd2, 4'b0000, 1'b1};
    tbl[10] = '{4'b0100, 1'b0, 2'd2, 4'b0000, 1'b1};
    tbl[11] = '{4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1};
    tbl[12] = '{4'b1001, 1'b1, 2'd3, 4'b1000, 1'b1};
    tbl[13] = '{4'b1001, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[14] = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0};
    tbl[15] = '{4'b0001, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[16] = '{4'b0011, 1'b0, 2'd1, 4'b0000, 1'b1};
    tbl[17] = '{4'b0011, 1'b1, 2'd1, 4'b0010, 1'b1};
    tbl[18] = '{4'b0011, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[19] = '{4'b1110, 1'b1, 2'd1, 4'b0010, 1'b1};
    req_data = pack(4'hF);
    for (int i = 0; i < 20; i++) begin
      req_valid  = tbl[i].valid;
      push_grant = tbl[i].grant;
      base  = 32'hA0 + 32'(tbl[i].owner);
      exp_d = tbl[i].pvalid ? {1'b1, base} : '0;
      #3;
      chk($sformatf("tbl%0d_owner", i),  64'(owner),      64'(tbl[i].owner));
      chk($sformatf("tbl%0d_grant", i),  64'(req_grant),  64'(tbl[i].gnt));
      chk($sformatf("tbl%0d_pvalid", i), 64'(push_valid), 64'(tbl[i].pvalid));
      chk($sformatf("tbl%0d_data", i),   64'(push_data),  64'(exp_d));
      chk($sformatf("tbl%0d_busy", i),   64'(busy),       64'd0);
      next_cycle();
    end

`ifdef ARB_PACKET_LOCK_EN
    // r0 single beat, then r1 three-beat packet, r2 must wait for the lock
    do_reset();
    req_valid = 4'b0111; push_grant = 1'b1;
    req_data = pack(4'b1111); #3;
    chk("pkt_c1_owner", 64'(owner), 64'd0); chk("pkt_c1_busy", 64'(busy), 64'd0);
    next_cycle();
    req_data = pack(4'b1101); #3;
    chk("pkt_c2_owner", 64'(owner), 64'd1); chk("pkt_c2_busy", 64'(busy), 64'd0);
    next_cycle();
    req_data = pack(4'b1101); #3;
    chk("pkt_c3_owner", 64'(owner), 64'd1); chk("pkt_c3_busy", 64'(busy), 64'd1);
    chk("pkt_c3_grant", 64'(req_grant), 64'b0010);
    next_cycle();
    req_data = pack(4'b1111); #3;
    chk("pkt_c4_owner", 64'(owner), 64'd1); chk("pkt_c4_busy", 64'(busy), 64'd1);
    chk("pkt_c4_grant", 64'(req_grant), 64'b0010);
    next_cycle();
    #3;
    chk("pkt_c5_owner", 64'(owner), 64'd2); chk("pkt_c5_busy", 64'(busy), 64'd0);
    next_cycle();

    // Reset in the middle of a packet from r2
    do_reset();
    req_valid = 4'b0100; req_data = pack(4'b1011); push_grant = 1'b1; #3;
    chk("mid_c1_owner", 64'(owner), 64'd2);
    next_cycle();
    #3;
    chk("mid_c2_busy", 64'(busy), 64'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_busy",   64'(busy),       64'd0);
    chk("mid_rst_pvalid", 64'(push_valid), 64'd0);
    chk("mid_rst_owner",  64'(owner),      64'd0);
    next_cycle();
    rst_n = 1'b1; m_ptr = 0; m_lock = -1;
    req_valid = 4'b0101; req_data = pack(4'hF); #3;
    chk("mid_rel_owner", 64'(owner), 64'd0);
    chk("mid_rel_busy",  64'(busy),  64'd0);
    next_cycle();
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid  = 4'($urandom);
      push_grant = ($urandom_range(0, 3) != 0);
      req_data   = pack(4'($urandom));
      for (int i = 0; i < N; i++) req_data[i*PW +: DW] = $urandom;
      model_eval(req_valid, push_grant, req_data, sel, pv, gnt, data);
      #3;
      chk($sformatf("rnd%0d_pvalid", c), 64'(push_valid), 64'(pv));
      chk($sformatf("rnd%0d_grant", c),  64'(req_grant),  64'(gnt));
      chk($sformatf("rnd%0d_data", c),   64'(push_data),  64'(data));
      chk($sformatf("rnd%0d_owner", c),  64'(owner),      64'((pv || m_lock >= 0) ? sel : 0));
      chk($sformatf("rnd%0d_busy", c),   64'(busy),       64'(m_lock >= 0));
      model_step(req_valid, push_grant, req_data);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
